// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares one registered CDB beat among NUM_REQ units,
// each behind a 1-entry buffer. CDB_FIXED_PRIO_EN: fixed priority.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_store_i,
  output logic                      cdb_valid_o,
  output logic [TAG_W-1:0]          cdb_rob_tag_o,
  output logic [DATA_W-1:0]         cdb_data_o,
  output logic [DATA_W-1:0]         cdb_store_data_o,
  output logic [NUM_REQ-1:0]        cdb_yumi_o
);

  localparam int PTR_W =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] full_q;
  logic [TAG_W-1:0]   tag_q   [NUM_REQ];
  logic [DATA_W-1:0]  data_q  [NUM_REQ];
  logic [DATA_W-1:0]  store_q [NUM_REQ];

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [NUM_REQ-1:0] acc;

`ifdef CDB_FIXED_PRIO_EN
  // lowest-index full buffer wins
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (full_q[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        gnt_idx  = PTR_W'(i);
        gnt_any  = 1'b1;
      end
    end
  end
`else
  logic [PTR_W-1:0] rr_ptr_q;

  // first full buffer at or after rr_ptr, wrapping
  always_comb begin
    int idx;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_any && full_q[idx]) begin
        grant[idx] = 1'b1;
        gnt_idx    = PTR_W'(idx);
        gnt_any    = 1'b1;
      end
    end
  end

  // pointer steps past the winner; a flush leaves it alone
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_q <= '0;
    end else if (!flush_i && gnt_any) begin
      if (gnt_idx == PTR_W'(NUM_REQ - 1))
        rr_ptr_q <= '0;
      else
        rr_ptr_q <= gnt_idx + PTR_W'(1);
    end
  end
`endif

  // a draining buffer may refill in the same cycle
  assign req_ready_o = ~full_q | grant;
  assign acc         = req_valid_i & req_ready_o;

  // payload captured on every accepted handshake
  always_ff @(posedge clk_i) begin
    for (int r = 0; r < NUM_REQ; r++) begin
      if (acc[r]) begin
        tag_q[r]   <= req_tag_i[r*TAG_W +: TAG_W];
        data_q[r]  <= req_data_i[r*DATA_W +: DATA_W];
        store_q[r] <= req_store_i[r*DATA_W +: DATA_W];
      end
    end
  end

  // occupancy and registered CDB beat; flush drops everything
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      full_q           <= '0;
      cdb_valid_o      <= 1'b0;
      cdb_rob_tag_o    <= '0;
      cdb_data_o       <= '0;
      cdb_store_data_o <= '0;
      cdb_yumi_o       <= '0;
    end else begin
      full_q      <= (full_q & ~grant) | acc;
      cdb_valid_o <= gnt_any;
      cdb_yumi_o  <= grant;
      if (gnt_any) begin
        cdb_rob_tag_o    <= tag_q[gnt_idx];
        cdb_data_o       <= data_q[gnt_idx];
        cdb_store_data_o <= store_q[gnt_idx];
      end else begin
        cdb_rob_tag_o    <= '0;
        cdb_data_o       <= '0;
        cdb_store_data_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed + random stimulus, queue scoreboard
// against a per-unit buffer model of the arbitration rules.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int TW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_i;
  logic            flush_i;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_ready_o;
  logic [N*TW-1:0] req_tag_i;
  logic [N*DW-1:0] req_data_i;
  logic [N*DW-1:0] req_store_i;
  logic            cdb_valid_o;
  logic [TW-1:0]   cdb_rob_tag_o;
  logic [DW-1:0]   cdb_data_o;
  logic [DW-1:0]   cdb_store_data_o;
  logic [N-1:0]    cdb_yumi_o;

  cdb_arbiter #(
    .NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .flush_i          (flush_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_tag_i        (req_tag_i),
    .req_data_i       (req_data_i),
    .req_store_i      (req_store_i),
    .cdb_valid_o      (cdb_valid_o),
    .cdb_rob_tag_o    (cdb_rob_tag_o),
    .cdb_data_o       (cdb_data_o),
    .cdb_store_data_o (cdb_store_data_o),
    .cdb_yumi_o       (cdb_yumi_o)
  );

  // unit-side stimulus; valid stays up until accepted
  logic [N-1:0]  v;
  logic [TW-1:0] t [N];
  logic [DW-1:0] d [N];
  logic [DW-1:0] s [N];

  assign req_valid_i = v;

  always_comb begin
    req_tag_i   = '0;
    req_data_i  = '0;
    req_store_i = '0;
    for (int r = 0; r < N; r++) begin
      req_tag_i[r*TW +: TW]   = t[r];
      req_data_i[r*DW +: DW]  = d[r];
      req_store_i[r*DW +: DW] = s[r];
    end
  end

  // reference model: one slot per unit plus scan pointer
  bit            m_full  [N];
  logic [TW-1:0] m_tag   [N];
  logic [DW-1:0] m_data  [N];
  logic [DW-1:0] m_store [N];
  int            m_rr;

  typedef struct {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
    logic [DW-1:0] store;
    logic [N-1:0]  yumi;
    int            cyc;
  } beat_t;

  beat_t exp_q [$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int m_grant();
    for (int i = 0; i < N; i++) begin
`ifdef CDB_FIXED_PRIO_EN
      if (m_full[i]) return i;
`else
      if (m_full[(m_rr + i) % N]) return (m_rr + i) % N;
`endif
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] rdy;
    int g;
    g = m_grant();
    for (int r = 0; r < N; r++)
      rdy[r] = !m_full[r] || (r == g);
    return rdy;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // one clock: check ready, advance model at the edge
  task automatic tick();
    logic [N-1:0] rdy;
    int g;
    beat_t e;
    rdy = m_ready();
    g   = m_grant();
    @(negedge clk);
    if (mon_en) chk("ready", 32'(req_ready_o), 32'(rdy));
    @(posedge clk);
    #1;
    if (reset_i) begin
      for (int r = 0; r < N; r++) m_full[r] = 1'b0;
      m_rr = 0;
    end else if (flush_i) begin
      for (int r = 0; r < N; r++) m_full[r] = 1'b0;
    end else begin
      if (g >= 0) begin
        e.tag     = m_tag[g];
        e.data    = m_data[g];
        e.store   = m_store[g];
        e.yumi    = '0;
        e.yumi[g] = 1'b1;
        e.cyc     = cyc;
        exp_q.push_back(e);
        m_full[g] = 1'b0;
        m_rr      = (g + 1) % N;
      end
      for (int r = 0; r < N; r++) begin
        if (v[r] && rdy[r]) begin
          m_full[r]  = 1'b1;
          m_tag[r]   = t[r];
          m_data[r]  = d[r];
          m_store[r] = s[r];
        end
      end
    end
    for (int r = 0; r < N; r++)
      if (v[r] && rdy[r]) v[r] = 1'b0;
  endtask

  task automatic put(input int r, input int tg);
    v[r] = 1'b1;
    t[r] = TW'(tg);
    d[r] = $urandom;
    s[r] = $urandom;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // monitor: every beat must match the next expected one
  always @(negedge clk) begin
    if (mon_en) begin
      beat_t e;
      n_cmp++;
      if (cdb_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL beat: unexpected tag %h yumi %b",
                   cdb_rob_tag_o, cdb_yumi_o);
        end else begin
          e = exp_q.pop_front();
          if ({cdb_rob_tag_o, cdb_data_o,
               cdb_store_data_o, cdb_yumi_o} !==
              {e.tag, e.data, e.store, e.yumi} ||
              cyc != e.cyc) begin
            n_err++;
            $display({"FAIL beat: got %h/%h/%h/%b @%0d ",
                      "want %h/%h/%h/%b @%0d"},
                     cdb_rob_tag_o, cdb_data_o,
                     cdb_store_data_o, cdb_yumi_o, cyc,
                     e.tag, e.data, e.store, e.yumi, e.cyc);
          end
        end
      end else if (cdb_valid_o === 1'b0) begin
        if ({cdb_rob_tag_o, cdb_data_o,
             cdb_store_data_o, cdb_yumi_o} !== '0) begin
          n_err++;
          $display("FAIL idle: fields nonzero yumi %b tag %h",
                   cdb_yumi_o, cdb_rob_tag_o);
        end
      end else begin
        n_err++;
        $display("FAIL valid: unknown %b", cdb_valid_o);
      end
    end
  end

  initial begin
    v       = '0;
    reset_i = 1'b1;
    flush_i = 1'b0;
    m_rr    = 0;
    for (int r = 0; r < N; r++) begin
      t[r] = '0; d[r] = '0; s[r] = '0;
      m_full[r] = 1'b0;
    end

    // reset
    tick();
    mon_en = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("rst_valid", 32'(cdb_valid_o), 32'd0);
    chk("rst_yumi", 32'(cdb_yumi_o), 32'd0);
    chk("rst_ready", 32'(req_ready_o), 32'hf);

    // single alu result, 2-cycle latency
    v[3] = 1'b1; t[3] = 4'd5;
    d[3] = 32'h1234; s[3] = 32'hABCD;
    tick();
    tick();
    chk("one_valid", 32'(cdb_valid_o), 32'd1);
    chk("one_tag", 32'(cdb_rob_tag_o), 32'd5);
    chk("one_data", cdb_data_o, 32'h1234);
    chk("one_store", cdb_store_data_o, 32'hABCD);
    chk("one_yumi", 32'(cdb_yumi_o), 32'b1000);
    tick();
    chk("one_after", 32'(cdb_valid_o), 32'd0);
    drain(2);

    // contention: all four at once
    for (int r = 0; r < N; r++) put(r, r + 1);
    tick();
    for (int r = 0; r < N; r++) begin
      tick();
      chk("cont_yumi", 32'(cdb_yumi_o), 32'(1 << r));
      chk("cont_tag", 32'(cdb_rob_tag_o), 32'(r + 1));
    end
    drain(2);

    // back-to-back mul, no bubbles
    for (int i = 0; i < 8; i++) begin
      put(1, i);
      tick();
      if (i > 0) begin
        chk("b2b_valid", 32'(cdb_valid_o), 32'd1);
        chk("b2b_tag", 32'(cdb_rob_tag_o), 32'(i - 1));
      end
    end
    tick();
    chk("b2b_last", 32'(cdb_rob_tag_o), 32'd7);
    drain(2);

    // flush with div and mul buffered
    put(0, 9);
    put(1, 10);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fl_valid", 32'(cdb_valid_o), 32'd0);
    chk("fl_ready", 32'(req_ready_o), 32'hf);
    drain(3);
    put(3, 6);
    tick();
    tick();
    chk("fl_alu_yumi", 32'(cdb_yumi_o), 32'b1000);
    chk("fl_alu_tag", 32'(cdb_rob_tag_o), 32'd6);
    drain(2);

    // wrap: winner after unit 3 is unit 0
    put(2, 2);
    put(3, 3);
    tick();
    put(0, 4'hA);
    put(2, 4'hB);
    tick();
    chk("wrap_y0", 32'(cdb_yumi_o), 32'b0100);
    tick();
`ifdef CDB_FIXED_PRIO_EN
    chk("wrap_y1", 32'(cdb_yumi_o), 32'b0001);
    tick();
    chk("wrap_y2", 32'(cdb_yumi_o), 32'b0100);
    drain(3);
    // div held every cycle starves alu
    put(3, 7);
    for (int i = 0; i < 10; i++) begin
      put(0, i);
      tick();
      chk("starve", 32'(cdb_yumi_o[3]), 32'd0);
    end
    drain(4);
`else
    chk("wrap_y1", 32'(cdb_yumi_o), 32'b1000);
    tick();
    chk("wrap_y2", 32'(cdb_yumi_o), 32'b0001);
    tick();
    chk("wrap_y3", 32'(cdb_yumi_o), 32'b0100);
    drain(3);
`endif

    // random traffic with flush and reset
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < N; r++)
        if (!v[r] && $urandom_range(0, 2) == 0)
          put(r, $urandom_range(0, 15));
      flush_i = ($urandom_range(0, 39) == 0);
      reset_i = ($urandom_range(0, 299) == 0);
      tick();
    end
    flush_i = 1'b0;
    reset_i = 1'b0;
    v = '0;
    drain(8);
    chk("q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
